// File: rtl/proc_pkg.sv
// proc_pkg: shared constants and sizing helpers for datapath blocks
package proc_pkg;
  localparam int XLEN = 32;
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/mux_n_comb.sv
// mux_n_comb: combinational N-way select with default value and illegal-code flag
module mux_n_comb
  import proc_pkg::*;
#(
  parameter int WIDTH = XLEN,
  parameter int N = 5,
  parameter logic [WIDTH-1:0] DEFAULT_VAL = '0,
  localparam int SELW = clog2_min1(N)
) (
  input  logic [N*WIDTH-1:0] data,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   word,
  output logic               err
);
  assign err = (N == (1 << SELW)) ? 1'b0 : (32'(sel) >= 32'(N));
  always_comb begin
    word = DEFAULT_VAL;
    for (int k = 0; k < N; k++) word = (32'(sel) == 32'(k)) ? data[k*WIDTH +: WIDTH] : word;
  end
endmodule

// File: rtl/pipe_mux_n.sv
// pipe_mux_n: registered N-way select with valid/ready, skid buffer and sticky error
module pipe_mux_n
  import proc_pkg::*;
#(
  parameter int WIDTH = XLEN,
  parameter int N = 5,
  parameter logic [WIDTH-1:0] DEFAULT_VAL = '0,
  localparam int SELW = clog2_min1(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SELW-1:0]    in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_err,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               err_sticky,
  input  logic               err_clr
);
  logic [WIDTH-1:0] new_data, main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic new_err, main_err_q, main_err_d, skid_err_q, skid_err_d;
  logic main_valid_q, main_valid_d, skid_valid_q, skid_valid_d, sticky_q, sticky_d;
  logic accept, load_main;
  mux_n_comb #(.WIDTH(WIDTH), .N(N), .DEFAULT_VAL(DEFAULT_VAL)) u_mux (
    .data(in_data),
    .sel (in_sel),
    .word(new_data),
    .err (new_err)
  );
  assign accept    = in_valid & ~skid_valid_q;
  assign load_main = ~main_valid_q | out_ready;
  always_comb begin
    main_valid_d = load_main ? (skid_valid_q | accept) : 1'b1;
    main_data_d  = !load_main ? main_data_q : skid_valid_q ? skid_data_q : accept ? new_data : main_data_q;
    main_err_d   = !load_main ? main_err_q : skid_valid_q ? skid_err_q : accept ? new_err : main_err_q;
    skid_valid_d = load_main ? 1'b0 : (skid_valid_q | accept);
    skid_data_d  = (!load_main && accept) ? new_data : skid_data_q;
    skid_err_d   = (!load_main && accept) ? new_err : skid_err_q;
    sticky_d     = (accept && new_err) ? 1'b1 : err_clr ? 1'b0 : sticky_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_err_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_err_q   <= 1'b0;
      sticky_q     <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_err_q   <= main_err_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_err_q   <= skid_err_d;
      sticky_q     <= sticky_d;
    end
  end
  assign in_ready   = ~skid_valid_q;
  assign out_valid  = main_valid_q;
  assign out_data   = main_data_q;
  assign out_err    = main_err_q;
  assign err_sticky = sticky_q;
endmodule

// File: tb/tb_pipe_mux_n.sv
// tb_pipe_mux_n: directed and randomized scoreboard checks of pipe_mux_n across N/WIDTH variants
module tb_pipe_mux_n;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0, err_clr = 1'b0;
  logic [3:0] sel = '0;
  logic [255:0] in_data = '0;
  logic [3:0] rdy, ov, oe, st;
  logic [31:0] od [4];
  logic [7:0] od3;
  int checks = 0, failures = 0;
  int nn [4] = '{5, 2, 8, 16};
  int ww [4] = '{32, 32, 32, 8};
  logic [32:0] qd [4][$];
  logic sticky_m [4];
  always #5 clk = ~clk;
  pipe_mux_n #(.WIDTH(32), .N(5), .DEFAULT_VAL(32'h0)) u0 (
    .clk(clk), .rst(rst), .in_data(in_data[159:0]), .in_sel(sel[2:0]), .in_valid(in_valid),
    .in_ready(rdy[0]), .out_data(od[0]), .out_err(oe[0]), .out_valid(ov[0]), .out_ready(out_ready),
    .err_sticky(st[0]), .err_clr(err_clr)
  );
  pipe_mux_n #(.WIDTH(32), .N(2), .DEFAULT_VAL(32'h0)) u1 (
    .clk(clk), .rst(rst), .in_data(in_data[63:0]), .in_sel(sel[0:0]), .in_valid(in_valid),
    .in_ready(rdy[1]), .out_data(od[1]), .out_err(oe[1]), .out_valid(ov[1]), .out_ready(out_ready),
    .err_sticky(st[1]), .err_clr(err_clr)
  );
  pipe_mux_n #(.WIDTH(32), .N(8), .DEFAULT_VAL(32'h0)) u2 (
    .clk(clk), .rst(rst), .in_data(in_data[255:0]), .in_sel(sel[2:0]), .in_valid(in_valid),
    .in_ready(rdy[2]), .out_data(od[2]), .out_err(oe[2]), .out_valid(ov[2]), .out_ready(out_ready),
    .err_sticky(st[2]), .err_clr(err_clr)
  );
  pipe_mux_n #(.WIDTH(8), .N(16), .DEFAULT_VAL(8'h0)) u3 (
    .clk(clk), .rst(rst), .in_data(in_data[127:0]), .in_sel(sel[3:0]), .in_valid(in_valid),
    .in_ready(rdy[3]), .out_data(od3), .out_err(oe[3]), .out_valid(ov[3]), .out_ready(out_ready),
    .err_sticky(st[3]), .err_clr(err_clr)
  );
  assign od[3] = {24'h0, od3};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [32:0] ref_out(input int d);
    int s = int'(sel) % (1 << $clog2(nn[d]));
    logic [255:0] t = in_data >> (s * ww[d]);
    if (s >= nn[d]) return {1'b1, 32'h0};
    return {1'b0, (ww[d] == 32) ? t[31:0] : (t[31:0] & 32'hff)};
  endfunction
  initial begin
    for (int k = 0; k < 8; k++) in_data[k*32 +: 32] = 32'h1000 + k;
    #1;
    check("rst_valid", ov[0], 0);
    check("rst_data", od[0], 0);
    check("rst_err", oe[0], 0);
    check("rst_sticky", st[0], 0);
    check("rst_ready", rdy[0], 1);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1; sel = 4'd3; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("single_valid", ov[0], 1);
    check("single_data", od[0], 32'h1003);
    check("single_err", oe[0], 0);
    @(negedge clk);
    check("single_drain", ov[0], 0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; sel = 4'(i);
      check("stream_ready", rdy[0], 1);
      @(negedge clk);
      check("stream_valid", ov[0], 1);
      check("stream_data", od[0], 32'h1000 + i);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("stream_end", ov[0], 0);
    out_ready = 1'b0; in_valid = 1'b1; sel = 4'd1;
    @(negedge clk);
    check("bp_data1", od[0], 32'h1001);
    check("bp_ready1", rdy[0], 1);
    sel = 4'd2;
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_ready2", rdy[0], 0);
    check("bp_hold1", od[0], 32'h1001);
    @(negedge clk);
    check("bp_hold2", od[0], 32'h1001);
    check("bp_ready3", rdy[0], 0);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_data2", od[0], 32'h1002);
    check("bp_valid2", ov[0], 1);
    check("bp_ready4", rdy[0], 1);
    @(negedge clk);
    check("bp_drain", ov[0], 0);
    in_valid = 1'b1; sel = 4'd6;
    @(negedge clk);
    in_valid = 1'b0;
    check("ill_data", od[0], 0);
    check("ill_err", oe[0], 1);
    check("ill_sticky", st[0], 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("clr_sticky", st[0], 0);
    err_clr = 1'b1; in_valid = 1'b1; sel = 4'd7;
    @(negedge clk);
    err_clr = 1'b0; in_valid = 1'b0;
    check("setwins_sticky", st[0], 1);
    check("setwins_err", oe[0], 1);
    out_ready = 1'b0; in_valid = 1'b1; sel = 4'd0;
    @(negedge clk);
    sel = 4'd1;
    @(negedge clk);
    in_valid = 1'b0;
    check("full_ready", rdy[0], 0);
    check("full_valid", ov[0], 1);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", ov[0], 0);
    check("arst_ready", rdy[0], 1);
    check("arst_sticky", st[0], 0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_valid", ov[0], 0);
    @(negedge clk);
    check("post_rst_valid2", ov[0], 0);
    for (int d = 0; d < 4; d++) sticky_m[d] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      for (int d = 0; d < 4; d++) begin
        check($sformatf("rnd_ready%0d", d), rdy[d], qd[d].size() < 2);
        check($sformatf("rnd_valid%0d", d), ov[d], qd[d].size() > 0);
        check($sformatf("rnd_sticky%0d", d), st[d], sticky_m[d]);
        if (qd[d].size() > 0) begin
          check($sformatf("rnd_data%0d", d), od[d], qd[d][0][31:0]);
          check($sformatf("rnd_err%0d", d), oe[d], qd[d][0][32]);
        end
      end
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      err_clr = $urandom_range(0, 15) == 0;
      sel = 4'($urandom);
      for (int k = 0; k < 8; k++) in_data[k*32 +: 32] = $urandom;
      for (int d = 0; d < 4; d++) begin
        logic acc, xfer;
        logic [32:0] r;
        acc = in_valid && qd[d].size() < 2;
        xfer = out_ready && qd[d].size() > 0;
        r = ref_out(d);
        if (xfer) void'(qd[d].pop_front());
        if (acc) qd[d].push_back(r);
        sticky_m[d] = (acc && r[32]) ? 1'b1 : err_clr ? 1'b0 : sticky_m[d];
      end
      @(negedge clk);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
